// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl shared types: FSM state encoding and counting-mode constants.
// Imported by the timer controller and its counter sub-module.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_ctrl_count.sv
// WIDTH-bit up-counter with synchronous clear, advance enable and
// wrap-to-zero on reaching the limit; term flags count == limit.
module timer_ctrl_count
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    assign term = (count == limit);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= term ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Interval-timer controller: IDLE/RUN/PAUSE sequencing, limit and mode
// registers, irq/overrun flags. Optional prescaler: TIMER_CTRL_PRESCALE_EN.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_LIMIT = 15
`ifdef TIMER_CTRL_PRESCALE_EN
    ,
    parameter int PRESCALE      = 4
`endif
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic             limit_wr,
    input  logic [WIDTH-1:0] limit_in,
    input  logic             irq_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done_pulse,
    output logic             irq,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] LIM_RST = WIDTH'(DEFAULT_LIMIT);

    state_t           state;
    state_t           nstate;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] limit_run;
    logic             mode_q;
    logic             tick;
    logic             term;
    logic             cnt_clr;
    logic             cnt_en;
    logic             term_ev;
    logic             start_idle;

`ifdef TIMER_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = (pre == PMAX);

    // Phase is kept across PAUSE so a resume finishes the partial interval.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pre <= '0;
        end else if (state == RUN) begin
            if (!stop) begin
                pre <= tick ? '0 : pre + PW'(1);
            end
        end else if (state == IDLE || stop) begin
            pre <= '0;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign start_idle = (state == IDLE) && start;

    always_comb begin
        nstate  = state;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        term_ev = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nstate  = RUN;
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    nstate = PAUSE;
                end else if (tick) begin
                    cnt_en  = 1'b1;
                    term_ev = term;
                    if (term && mode_q == MODE_ONESHOT) begin
                        nstate = IDLE;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    nstate  = IDLE;
                    cnt_clr = 1'b1;
                end else if (start) begin
                    nstate = RUN;
                end
            end
            default: begin
                nstate  = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // limit_run snapshots the old limit so a same-edge write waits a period.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            limit_q   <= LIM_RST;
            limit_run <= LIM_RST;
            mode_q    <= MODE_ONESHOT;
        end else begin
            if (state == IDLE && limit_wr) begin
                limit_q <= limit_in;
            end
            if (start_idle) begin
                limit_run <= limit_q;
                mode_q    <= mode;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            done_pulse <= 1'b0;
            irq        <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            done_pulse <= term_ev;
            if (term_ev) begin
                irq <= 1'b1;
                if (irq && !irq_ack) begin
                    overrun <= 1'b1;
                end
            end else if (irq_ack) begin
                irq     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

    timer_ctrl_count #(
        .WIDTH (WIDTH)
    ) u_count (
        .clock   (clock),
        .clear_n (clear_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (limit_run),
        .count   (count),
        .term    (term)
    );

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed steps plus random traffic
// compared every cycle against a behavioural model of the timer.
module tb_timer_ctrl;

    localparam int W = 4;
`ifdef TIMER_CTRL_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic         clock;
    logic         clear_n;
    logic         start;
    logic         stop;
    logic         mode;
    logic         limit_wr;
    logic [W-1:0] limit_in;
    logic         irq_ack;
    logic [W-1:0] count;
    logic         busy;
    logic         done_pulse;
    logic         irq;
    logic         overrun;

    int n_chk;
    int n_fail;

    // model state
    bit m_active;
    bit m_paused;
    int m_cnt;
    int m_lim;
    int m_rlim;
    bit m_mode;
    int m_ph;
    bit m_irq;
    bit m_ovr;
    bit m_done;

    timer_ctrl #(
        .WIDTH         (W),
        .DEFAULT_LIMIT (15)
`ifdef TIMER_CTRL_PRESCALE_EN
        ,
        .PRESCALE      (PS)
`endif
    ) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .limit_wr   (limit_wr),
        .limit_in   (limit_in),
        .irq_ack    (irq_ack),
        .count      (count),
        .busy       (busy),
        .done_pulse (done_pulse),
        .irq        (irq),
        .overrun    (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_paused = 0;
        m_cnt    = 0;
        m_lim    = 15;
        m_rlim   = 15;
        m_mode   = 0;
        m_ph     = 0;
        m_irq    = 0;
        m_ovr    = 0;
        m_done   = 0;
    endtask

    // One clock edge of the timer, written from the behavioural rules.
    task automatic model_step();
        bit term;
        int old_lim;
        term    = 0;
        old_lim = m_lim;
        if (!m_active) begin
            if (limit_wr) m_lim = int'(limit_in);
            if (start) begin
                m_active = 1;
                m_paused = 0;
                m_cnt    = 0;
                m_ph     = 0;
                m_rlim   = old_lim;
                m_mode   = mode;
            end
        end else if (!m_paused) begin
            if (stop) begin
                m_paused = 1;
            end else if (m_ph == PS - 1) begin
                m_ph = 0;
                if (m_cnt == m_rlim) begin
                    m_cnt = 0;
                    term  = 1;
                    if (!m_mode) m_active = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else begin
                m_ph = m_ph + 1;
            end
        end else begin
            if (stop) begin
                m_active = 0;
                m_paused = 0;
                m_cnt    = 0;
                m_ph     = 0;
            end else if (start) begin
                m_paused = 0;
            end
        end
        if (term) begin
            if (m_irq && !irq_ack) m_ovr = 1;
            m_irq = 1;
        end else if (irq_ack) begin
            m_irq = 0;
            m_ovr = 0;
        end
        m_done = term;
    endtask

    task automatic check_all();
        chk("count", int'(count), m_cnt);
        chk("busy", int'(busy), int'(m_active));
        chk("done_pulse", int'(done_pulse), int'(m_done));
        chk("irq", int'(irq), int'(m_irq));
        chk("overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic drive(input bit st, input bit sp, input bit md,
                         input bit lw, input int li, input bit ack);
        start    = st;
        stop     = sp;
        mode     = md;
        limit_wr = lw;
        limit_in = W'(li);
        irq_ack  = ack;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_step();
            #1;
            check_all();
        end
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        cyc(n);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        clear_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_pulse), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_ovr", int'(overrun), 0);
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;

        // default limit 15, one-shot
        drive(1, 0, 0, 0, 0, 0);
        cyc(1);
        idle(16 * PS + 2);
        drive(0, 0, 0, 0, 0, 1);
        cyc(1);

        // auto-reload, limit 3, overrun without ack
        drive(0, 0, 0, 1, 3, 0);
        cyc(1);
        drive(1, 0, 1, 0, 0, 0);
        cyc(1);
        idle(12 * PS);
        chk("reload_ovr", int'(overrun), 1);
        drive(0, 0, 0, 0, 0, 1);
        cyc(1);
        drive(0, 1, 0, 0, 0, 0);
        cyc(2);
        chk("stop2_idle", int'(busy), 0);

        // one-shot limit 2, then restart
        drive(0, 0, 0, 1, 2, 1);
        cyc(1);
        drive(1, 0, 0, 0, 0, 0);
        cyc(1);
        idle(3 * PS + 2);
        drive(1, 0, 0, 0, 0, 0);
        cyc(1);
        idle(2 * PS);

        // pause and resume at count 4, limit 7
        idle(3 * PS);
        drive(0, 0, 0, 1, 7, 1);
        cyc(1);
        drive(1, 0, 1, 0, 0, 0);
        cyc(1);
        idle(4 * PS);
        drive(0, 1, 0, 0, 0, 0);
        cyc(1);
        idle(5);
        chk("pause_hold", int'(count), 4);
        drive(1, 0, 0, 0, 0, 0);
        cyc(1);
        idle(4 * PS);
        drive(0, 1, 0, 0, 0, 0);
        cyc(2);

        // terminal with ack on the same edge; start+stop in PAUSE
        drive(0, 0, 0, 1, 1, 0);
        cyc(1);
        drive(1, 0, 1, 0, 0, 0);
        cyc(1);
        drive(0, 0, 0, 0, 0, 1);
        cyc(6 * PS);
        drive(0, 1, 0, 0, 0, 0);
        cyc(1);
        drive(1, 1, 0, 0, 0, 0);
        cyc(1);
        chk("startstop_idle", int'(busy), 0);

        // limit write during RUN is ignored
        drive(1, 0, 1, 0, 0, 1);
        cyc(1);
        drive(0, 0, 0, 1, 9, 0);
        cyc(3 * PS);
        idle(4 * PS);

        // async reset at count 5 with limit 7
        drive(0, 1, 0, 0, 0, 1);
        cyc(2);
        drive(0, 0, 0, 1, 7, 0);
        cyc(1);
        drive(1, 0, 1, 0, 0, 0);
        cyc(1);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 200 && m_cnt != 5; i++) cyc(1);
        chk("wait_cnt5", int'(count), 5);
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_irq", int'(irq), 0);
        chk("arst_ovr", int'(overrun), 0);
        #1;
        clear_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        cyc(1);
        idle(16 * PS + 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(99) < 20, $urandom_range(99) < 8,
                  1'($urandom), $urandom_range(99) < 20,
                  int'($urandom_range(15)), $urandom_range(99) < 15);
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Programmable interval-timer controller that sequences a WIDTH-bit up-counter under software-style commands (start, stop/pause, limit load) and raises a level interrupt with acknowledge handshake on each terminal count. It sits between a control source (testbench, CSR decoder or higher-level FSM) and the counter datapath, and provides one-shot and auto-reload periodic operation.

## Interface

- WIDTH, 4, counter and limit width in bits (≥2)
- DEFAULT_LIMIT, 15, limit register value after reset
- PRESCALE, 4, clock cycles per counter advance; exists only with TIMER_CTRL_PRESCALE_EN (≥1)

- clock  input  1  rising-edge clock, single clock domain
- clear_n  input  1  asynchronous, active-low reset
- start  input  1  start from IDLE, or resume from PAUSE; sampled each edge
- stop  input  1  pause from RUN, or abort from PAUSE to IDLE
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled on the edge that accepts start from IDLE
- limit_wr  input  1  load limit_in into limit register; honoured only in IDLE
- limit_in  input  WIDTH  new terminal value
- irq_ack  input  1  clears irq and overrun
- count  output  WIDTH  current counter value
- busy  output  1  high in RUN or PAUSE
- done_pulse  output  1  one-cycle pulse per terminal count
- irq  output  1  sticky interrupt, set by terminal count
- overrun  output  1  sticky, terminal count occurred while irq still pending

## Operation

- States: IDLE, RUN, PAUSE. Reset: IDLE, count=0, limit_q=DEFAULT_LIMIT, mode_q=0, all flag outputs 0.
- IDLE: start → RUN, count=0, mode_q=mode. limit_wr → limit_q=limit_in. Both asserted on the same edge: limit loads, and the RUN period uses the old limit_q; the new limit applies from the next start.
- RUN, each advance: count==limit_q → terminal event, count=0; mode_q=0 → IDLE, mode_q=1 → stay RUN. Otherwise count=count+1. Wrap never exceeds limit_q; limit_q=0 → terminal on every advance.
- RUN: stop → PAUSE, count frozen. stop has priority over terminal detection on the same edge; no event.
- PAUSE: start → RUN, resume from held count. stop → IDLE, count=0. start and stop together → stop wins (IDLE).
- limit_wr outside IDLE: ignored, no side effect.
- Terminal event: done_pulse=1 for one cycle. irq set. If irq already 1 and irq_ack not asserted on the same edge → overrun set.
- irq_ack: clears irq and overrun. Ack on the same edge as a terminal event → irq stays 1, overrun unchanged.
- Async reset mid-operation: all state returns to reset values immediately; limit_q reverts to DEFAULT_LIMIT.

## Timing

- All outputs registered; nothing combinational from inputs to outputs.
- start accepted at edge E → busy=1 and count=0 after E. Increments follow at E+1, E+2, ….
- Period = limit_q+1 advances. Example: limit 3, start at E0 → count 1,2,3 after E1–E3. At E4: count=0, done_pulse=1, irq=1.
- One-shot: busy falls on the same edge that raises done_pulse.
- irq_ack at edge A → irq=0 after A.

## Configuration

- TIMER_CTRL_PRESCALE_EN defined: internal prescaler of ceil(log2(PRESCALE)) bits. The counter advances only on every PRESCALE-th clock in RUN. The prescaler is held in PAUSE and cleared on start from IDLE, on stop to IDLE, and on terminal event. Period = (limit_q+1)×PRESCALE clocks.
- Not defined: the counter advances on every RUN clock, no prescaler logic present, PRESCALE parameter absent.

## Structure

- Shared package timer_ctrl_pkg: state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2), mode constants MODE_ONESHOT=1'b0 and MODE_RELOAD=1'b1.
- One sub-module, timer_ctrl_count: WIDTH-bit counter with clear, enable and terminal-compare output (count==limit).
- Top level holds FSM, limit/mode registers, irq/overrun flags and the optional prescaler.

## Test plan

- Reset, limit_wr=1 limit_in=3, start mode=1, run 12 cycles → count 0,1,2,3,0…; done_pulse at cycles 4, 8, 12; irq stays 1, overrun=1 after the 2nd terminal without ack.
- One-shot with limit 2 → count 1,2 then 0, busy falls with the single done_pulse, state IDLE; a later start restarts from 0.
- Pause/resume: limit 7 at count=4, stop → count held at 4 for 5 cycles; start → 5,6,7, terminal; stop twice → IDLE, count=0.
- Simultaneous events: terminal with irq_ack on the same edge → irq=1, overrun=0; start+stop in PAUSE → IDLE; limit_wr during RUN → limit_q unchanged.
- Async reset while RUN at count 5 → count=0, busy=0, irq=0, limit_q=15 before the next clock edge.
- With TIMER_CTRL_PRESCALE_EN and PRESCALE=4, limit 1 → done_pulse every 8 clocks; pause holds the prescaler phase.
